// File: rtl/mau_reliable_recv_action_unit_if.sv
// Stream bundle for the reliable-receive action stage: PHV in with match result,
// PHV out, and the flowstate write-back broadcast.
interface mau_reliable_recv_action_unit_if #(
  parameter int PHV_WIDTH       = 456,
  parameter int FLOWSTATE_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10
);
  logic [PHV_WIDTH-1:0]       s_phv_info;
  logic                       s_phv_valid;
  logic                       s_phv_ready;
  logic                       s_phv_mat_hit;
  logic [FLOWSTATE_WIDTH-1:0] s_phv_mat_value;
  logic [ADDR_WIDTH-1:0]      s_phv_mat_addr;
  logic [PHV_WIDTH-1:0]       m_phv_info;
  logic                       m_phv_valid;
  logic                       m_phv_ready;
  logic [FLOWSTATE_WIDTH-1:0] bcd_flowstate_out;
  logic [ADDR_WIDTH-1:0]      bcd_addr_out;
  logic                       bcd_valid_out;

  // Design-side view.
  modport slave (
    input  s_phv_info, s_phv_valid, s_phv_mat_hit, s_phv_mat_value, s_phv_mat_addr,
    input  m_phv_ready,
    output s_phv_ready, m_phv_info, m_phv_valid,
    output bcd_flowstate_out, bcd_addr_out, bcd_valid_out
  );

  // Environment-side view.
  modport master (
    output s_phv_info, s_phv_valid, s_phv_mat_hit, s_phv_mat_value, s_phv_mat_addr,
    output m_phv_ready,
    input  s_phv_ready, m_phv_info, m_phv_valid,
    input  bcd_flowstate_out, bcd_addr_out, bcd_valid_out
  );
endinterface

// File: rtl/mau_reliable_recv_action_unit.sv
// Reliable-receive action stage: classifies DAT packets as in-order/duplicate/gap against
// the flow's expected PSN, marks ACK/NACK/drop and broadcasts the updated flowstate.
module mau_reliable_recv_action_unit #(
  parameter int PHV_WIDTH       = 456,
  parameter int PHV_B_COUNT     = 9,
  parameter int PHV_H_COUNT     = 2,
  parameter int PHV_W_COUNT     = 11,
  parameter int FLOWSTATE_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int BYPASS_DEPTH    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic reliable_enable,
  mau_reliable_recv_action_unit_if.slave bus
);

  localparam int PSN_W  = FLOWSTATE_WIDTH - 1;
  localparam int H_BASE = 8 * PHV_B_COUNT;
  localparam int W_BASE = H_BASE + 16 * PHV_H_COUNT;
  localparam int B0     = 0;
  localparam int B1     = 8;
  localparam int B5     = 40;
  localparam int H1     = H_BASE + 16;
  localparam int W_RPN  = W_BASE + 32 * 9;
  localparam int W_ACK  = W_BASE + 32 * (PHV_W_COUNT - 1);

  // PSN arithmetic is modulo 2^PSN_W.
  function automatic logic [PSN_W-1:0] psn_inc(input logic [PSN_W-1:0] v);
    return v + PSN_W'(1);
  endfunction

  function automatic logic [PSN_W-1:0] psn_dec(input logic [PSN_W-1:0] v);
    return v - PSN_W'(1);
  endfunction

  logic                       vld_p1;
  logic [PHV_WIDTH-1:0]       phv_p1;
  logic                       wr_reg;
  logic [FLOWSTATE_WIDTH-1:0] bcd_state_p1;
  logic [ADDR_WIDTH-1:0]      bcd_addr_p1;

  logic [BYPASS_DEPTH-1:0]    hist_vld;
  logic [ADDR_WIDTH-1:0]      hist_addr  [BYPASS_DEPTH];
  logic [FLOWSTATE_WIDTH-1:0] hist_state [BYPASS_DEPTH];

  logic                       ready_p0;
  logic                       accept_p0;
  logic [FLOWSTATE_WIDTH-1:0] eff_p0;
  logic [PSN_W-1:0]           rpn_p0;
  logic [PSN_W-1:0]           exp_p0;
  logic [PSN_W-1:0]           diff_p0;
  logic                       nack_p0;
  logic                       upd_p0;
  logic [FLOWSTATE_WIDTH-1:0] new_state_p0;
  logic [PHV_WIDTH-1:0]       phv_p0;

  assign ready_p0  = ~vld_p1 | bus.m_phv_ready;
  assign accept_p0 = bus.s_phv_valid & ready_p0;

  // Newest in-flight write to the same flow wins over the (possibly stale) table value.
  always_comb begin
    eff_p0 = bus.s_phv_mat_value;
    for (int i = BYPASS_DEPTH - 1; i >= 0; i--) begin
      if (hist_vld[i] && (hist_addr[i] == bus.s_phv_mat_addr)) eff_p0 = hist_state[i];
    end
  end

  assign rpn_p0  = bus.s_phv_info[W_RPN +: PSN_W];
  assign exp_p0  = eff_p0[PSN_W-1:0];
  assign nack_p0 = eff_p0[FLOWSTATE_WIDTH-1];
  assign diff_p0 = rpn_p0 - exp_p0;

  always_comb begin
    phv_p0       = bus.s_phv_info;
    upd_p0       = 1'b0;
    new_state_p0 = eff_p0;
    if (reliable_enable && bus.s_phv_info[B1+7] && bus.s_phv_info[B0+2]) begin
      if (!bus.s_phv_mat_hit) begin
        // Unknown flow: RST goes to the CPU for flow setup, anything else is dropped.
        if (bus.s_phv_info[B0+5]) begin
          phv_p0[B5 +: 8] = 8'd9;
        end else begin
          phv_p0[B5 +: 8] = 8'd15;
          phv_p0[B1+4]    = 1'b1;
        end
      end else begin
        phv_p0[H1 +: 16] = 16'(bus.s_phv_mat_addr);
        if (bus.s_phv_info[B0+5] || (diff_p0 == '0)) begin
          upd_p0              = 1'b1;
          new_state_p0        = {1'b0, psn_inc(bus.s_phv_info[B0+5] ? rpn_p0 : exp_p0)};
          phv_p0[B1+3]        = 1'b1;
          phv_p0[B1+5]        = 1'b1;
          phv_p0[W_ACK +: 32] = 32'(rpn_p0);
        end else if (diff_p0[PSN_W-1]) begin
          // Behind the window: re-ACK the last in-order PSN.
          phv_p0[B1+4]        = 1'b1;
          phv_p0[B1+5]        = 1'b1;
          phv_p0[W_ACK +: 32] = 32'(psn_dec(exp_p0));
        end else begin
          phv_p0[B1+4] = 1'b1;
          // Only the first packet past a hole raises a NACK; later ones drop silently.
          if (!nack_p0) begin
            upd_p0              = 1'b1;
            new_state_p0        = {1'b1, exp_p0};
            phv_p0[B1+6]        = 1'b1;
            phv_p0[W_ACK +: 32] = 32'(exp_p0);
          end
        end
      end
    end
  end

  // ---- p0 -> p1 register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      wr_reg       <= 1'b0;
      bcd_state_p1 <= '0;
      bcd_addr_p1  <= '0;
    end else if (accept_p0) begin
      vld_p1 <= 1'b1;
      wr_reg <= upd_p0;
      if (upd_p0) begin
        bcd_state_p1 <= new_state_p0;
        bcd_addr_p1  <= bus.s_phv_mat_addr;
      end
    end else if (bus.m_phv_ready) begin
      vld_p1 <= 1'b0;
      wr_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0) phv_p1 <= phv_p0;
  end

  // History advances with the pipe and freezes while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_vld <= '0;
    end else if (ready_p0) begin
      hist_vld[0] <= accept_p0 & upd_p0;
      for (int i = 1; i < BYPASS_DEPTH; i++) hist_vld[i] <= hist_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (ready_p0) begin
      hist_addr[0]  <= bus.s_phv_mat_addr;
      hist_state[0] <= new_state_p0;
      for (int i = 1; i < BYPASS_DEPTH; i++) begin
        hist_addr[i]  <= hist_addr[i-1];
        hist_state[i] <= hist_state[i-1];
      end
    end
  end

  assign bus.s_phv_ready       = ready_p0;
  assign bus.m_phv_valid       = vld_p1;
  assign bus.m_phv_info        = phv_p1;
  assign bus.bcd_flowstate_out = bcd_state_p1;
  assign bus.bcd_addr_out      = bcd_addr_p1;
  assign bus.bcd_valid_out     = vld_p1 & bus.m_phv_ready & wr_reg;

endmodule

// File: tb/tb_mau_reliable_recv_action_unit.sv
// Directed bench for mau_reliable_recv_action_unit: hand-computed PHV flags, ACK_PSN and
// write-back values for in-order, bypass, gap, duplicate, miss and backpressure cases.
module tb_mau_reliable_recv_action_unit;
  localparam int PW = 456;

  logic clk = 1'b0;
  logic rst;
  logic reliable_enable;
  int   n_cmp = 0;
  int   n_bad = 0;

  mau_reliable_recv_action_unit_if bus ();

  mau_reliable_recv_action_unit dut (
    .clk             (clk),
    .rst             (rst),
    .reliable_enable (reliable_enable),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // PHV with RECV_TABLE_EN set, TID 0x22, h[1] 0xBEEF, w[0] filler and RPN in w[9].
  function automatic logic [PW-1:0] mk_phv(input logic dat, input logic rstf, input logic [31:0] rpn);
    logic [PW-1:0] p;
    p            = '0;
    p[2]         = dat;
    p[5]         = rstf;
    p[15]        = 1'b1;
    p[47:40]     = 8'h22;
    p[103:88]    = 16'hBEEF;
    p[135:104]   = 32'hCAFEF00D;
    p[423:392]   = rpn;
    return p;
  endfunction

  task automatic drive(input logic [PW-1:0] p, input logic hit, input logic [31:0] val, input logic [9:0] addr);
    bus.s_phv_info      = p;
    bus.s_phv_mat_hit   = hit;
    bus.s_phv_mat_value = val;
    bus.s_phv_mat_addr  = addr;
    bus.s_phv_valid     = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.s_phv_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reliable_enable = 1'b1;
    bus.s_phv_valid = 1'b0;
    bus.s_phv_info = '0;
    bus.s_phv_mat_hit = 1'b0;
    bus.s_phv_mat_value = '0;
    bus.s_phv_mat_addr = '0;
    bus.m_phv_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_phv_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got %b want 0", bus.m_phv_valid); end
    n_cmp++; if (bus.bcd_valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_bcd_valid got %b want 0", bus.bcd_valid_out); end
    n_cmp++; if (bus.bcd_flowstate_out !== 32'd0) begin n_bad++; $display("FAIL rst_bcd_fs got %h want 0", bus.bcd_flowstate_out); end
    n_cmp++; if (bus.bcd_addr_out !== 10'd0) begin n_bad++; $display("FAIL rst_bcd_addr got %h want 0", bus.bcd_addr_out); end
    n_cmp++; if (bus.s_phv_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready got %b want 1", bus.s_phv_ready); end
  endtask

  task automatic test_in_order();
    idle(4);
    drive(mk_phv(1'b1, 1'b0, 32'd10), 1'b1, 32'd10, 10'd5);
    step();
    bus.s_phv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_phv_valid !== 1'b1) begin n_bad++; $display("FAIL io_m_valid got %b want 1", bus.m_phv_valid); end
    n_cmp++; if (bus.m_phv_info[13] !== 1'b1) begin n_bad++; $display("FAIL io_gen_ack got %b want 1", bus.m_phv_info[13]); end
    n_cmp++; if (bus.m_phv_info[11] !== 1'b1) begin n_bad++; $display("FAIL io_reli_hit got %b want 1", bus.m_phv_info[11]); end
    n_cmp++; if (bus.m_phv_info[455:424] !== 32'd10) begin n_bad++; $display("FAIL io_ack_psn got %h want 10", bus.m_phv_info[455:424]); end
    n_cmp++; if (bus.m_phv_info[103:88] !== 16'd5) begin n_bad++; $display("FAIL io_h1 got %h want 5", bus.m_phv_info[103:88]); end
    n_cmp++; if (bus.bcd_flowstate_out !== 32'd11) begin n_bad++; $display("FAIL io_bcd_fs got %h want 11", bus.bcd_flowstate_out); end
    n_cmp++; if (bus.bcd_addr_out !== 10'd5) begin n_bad++; $display("FAIL io_bcd_addr got %h want 5", bus.bcd_addr_out); end
    n_cmp++; if (bus.bcd_valid_out !== 1'b1) begin n_bad++; $display("FAIL io_bcd_valid got %b want 1", bus.bcd_valid_out); end
    step();
    @(negedge clk);
    n_cmp++; if (bus.m_phv_valid !== 1'b0) begin n_bad++; $display("FAIL io_drain_valid got %b want 0", bus.m_phv_valid); end
    n_cmp++; if (bus.bcd_valid_out !== 1'b0) begin n_bad++; $display("FAIL io_bcd_once got %b want 0", bus.bcd_valid_out); end
  endtask

  task automatic test_back_to_back();
    idle(4);
    for (int i = 0; i < 3; i++) begin
      drive(mk_phv(1'b1, 1'b0, 32'(10 + i)), 1'b1, 32'd10, 10'd5);
      step();
      if (i == 2) bus.s_phv_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.m_phv_info[13] !== 1'b1) begin n_bad++; $display("FAIL b2b_ack[%0d] got %b want 1", i, bus.m_phv_info[13]); end
      n_cmp++; if (bus.m_phv_info[14] !== 1'b0) begin n_bad++; $display("FAIL b2b_nack[%0d] got %b want 0", i, bus.m_phv_info[14]); end
      n_cmp++; if (bus.m_phv_info[455:424] !== 32'(10 + i)) begin n_bad++; $display("FAIL b2b_ack_psn[%0d] got %h want %h", i, bus.m_phv_info[455:424], 10 + i); end
      n_cmp++; if (bus.bcd_flowstate_out !== 32'(11 + i)) begin n_bad++; $display("FAIL b2b_bcd_fs[%0d] got %h want %h", i, bus.bcd_flowstate_out, 11 + i); end
      n_cmp++; if (bus.bcd_valid_out !== 1'b1) begin n_bad++; $display("FAIL b2b_bcd_valid[%0d] got %b want 1", i, bus.bcd_valid_out); end
    end
  endtask

  task automatic test_gap_retry();
    logic [31:0] rpns [3];
    logic        e_ack [3];
    logic        e_nack [3];
    logic        e_drop [3];
    logic        e_bv [3];
    logic [31:0] e_psn [3];
    logic [31:0] e_fs [3];
    rpns   = '{32'd14, 32'd15, 32'd13};
    e_ack  = '{1'b0, 1'b0, 1'b1};
    e_nack = '{1'b1, 1'b0, 1'b0};
    e_drop = '{1'b1, 1'b1, 1'b0};
    e_bv   = '{1'b1, 1'b0, 1'b1};
    e_psn  = '{32'd13, 32'd0, 32'd13};
    e_fs   = '{32'h8000000D, 32'h8000000D, 32'h0000000E};
    idle(4);
    for (int i = 0; i < 3; i++) begin
      drive(mk_phv(1'b1, 1'b0, rpns[i]), 1'b1, 32'd13, 10'd7);
      step();
      if (i == 2) bus.s_phv_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.m_phv_info[13] !== e_ack[i]) begin n_bad++; $display("FAIL gap_ack[%0d] got %b want %b", i, bus.m_phv_info[13], e_ack[i]); end
      n_cmp++; if (bus.m_phv_info[14] !== e_nack[i]) begin n_bad++; $display("FAIL gap_nack[%0d] got %b want %b", i, bus.m_phv_info[14], e_nack[i]); end
      n_cmp++; if (bus.m_phv_info[12] !== e_drop[i]) begin n_bad++; $display("FAIL gap_drop[%0d] got %b want %b", i, bus.m_phv_info[12], e_drop[i]); end
      n_cmp++; if (bus.m_phv_info[455:424] !== e_psn[i]) begin n_bad++; $display("FAIL gap_ack_psn[%0d] got %h want %h", i, bus.m_phv_info[455:424], e_psn[i]); end
      n_cmp++; if (bus.bcd_valid_out !== e_bv[i]) begin n_bad++; $display("FAIL gap_bcd_valid[%0d] got %b want %b", i, bus.bcd_valid_out, e_bv[i]); end
      n_cmp++; if (bus.bcd_flowstate_out !== e_fs[i]) begin n_bad++; $display("FAIL gap_bcd_fs[%0d] got %h want %h", i, bus.bcd_flowstate_out, e_fs[i]); end
    end
  endtask

  task automatic test_dup_wrap();
    idle(4);
    drive(mk_phv(1'b1, 1'b0, 32'h7FFFFFFF), 1'b1, 32'd0, 10'd3);
    step();
    bus.s_phv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_phv_info[12] !== 1'b1) begin n_bad++; $display("FAIL dup_drop got %b want 1", bus.m_phv_info[12]); end
    n_cmp++; if (bus.m_phv_info[13] !== 1'b1) begin n_bad++; $display("FAIL dup_ack got %b want 1", bus.m_phv_info[13]); end
    n_cmp++; if (bus.m_phv_info[455:424] !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL dup_ack_psn got %h want 7fffffff", bus.m_phv_info[455:424]); end
    n_cmp++; if (bus.bcd_valid_out !== 1'b0) begin n_bad++; $display("FAIL dup_bcd_valid got %b want 0", bus.bcd_valid_out); end
    drive(mk_phv(1'b1, 1'b0, 32'h7FFFFFFF), 1'b1, 32'h7FFFFFFF, 10'd4);
    step();
    bus.s_phv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_phv_info[13] !== 1'b1) begin n_bad++; $display("FAIL wrap_ack got %b want 1", bus.m_phv_info[13]); end
    n_cmp++; if (bus.m_phv_info[455:424] !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL wrap_ack_psn got %h want 7fffffff", bus.m_phv_info[455:424]); end
    n_cmp++; if (bus.bcd_flowstate_out !== 32'd0) begin n_bad++; $display("FAIL wrap_bcd_fs got %h want 0", bus.bcd_flowstate_out); end
    n_cmp++; if (bus.bcd_addr_out !== 10'd4) begin n_bad++; $display("FAIL wrap_bcd_addr got %h want 4", bus.bcd_addr_out); end
    n_cmp++; if (bus.bcd_valid_out !== 1'b1) begin n_bad++; $display("FAIL wrap_bcd_valid got %b want 1", bus.bcd_valid_out); end
  endtask

  task automatic test_hit_rst();
    idle(4);
    drive(mk_phv(1'b1, 1'b1, 32'd100), 1'b1, 32'h80000032, 10'd6);
    step();
    bus.s_phv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_phv_info[13] !== 1'b1) begin n_bad++; $display("FAIL hrst_ack got %b want 1", bus.m_phv_info[13]); end
    n_cmp++; if (bus.m_phv_info[11] !== 1'b1) begin n_bad++; $display("FAIL hrst_reli_hit got %b want 1", bus.m_phv_info[11]); end
    n_cmp++; if (bus.m_phv_info[455:424] !== 32'd100) begin n_bad++; $display("FAIL hrst_ack_psn got %h want 100", bus.m_phv_info[455:424]); end
    n_cmp++; if (bus.bcd_flowstate_out !== 32'd101) begin n_bad++; $display("FAIL hrst_bcd_fs got %h want 101", bus.bcd_flowstate_out); end
  endtask

  task automatic test_miss();
    logic [PW-1:0] p;
    idle(4);
    drive(mk_phv(1'b1, 1'b1, 32'd77), 1'b0, 32'd5, 10'd8);
    step();
    bus.s_phv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_phv_info[47:40] !== 8'd9) begin n_bad++; $display("FAIL miss_rst_tid got %0d want 9", bus.m_phv_info[47:40]); end
    n_cmp++; if (bus.m_phv_info[12] !== 1'b0) begin n_bad++; $display("FAIL miss_rst_drop got %b want 0", bus.m_phv_info[12]); end
    n_cmp++; if (bus.m_phv_info[103:88] !== 16'hBEEF) begin n_bad++; $display("FAIL miss_rst_h1 got %h want beef", bus.m_phv_info[103:88]); end
    n_cmp++; if (bus.bcd_valid_out !== 1'b0) begin n_bad++; $display("FAIL miss_rst_bcd got %b want 0", bus.bcd_valid_out); end
    drive(mk_phv(1'b1, 1'b0, 32'd77), 1'b0, 32'd5, 10'd8);
    step();
    bus.s_phv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_phv_info[47:40] !== 8'd15) begin n_bad++; $display("FAIL miss_tid got %0d want 15", bus.m_phv_info[47:40]); end
    n_cmp++; if (bus.m_phv_info[12] !== 1'b1) begin n_bad++; $display("FAIL miss_drop got %b want 1", bus.m_phv_info[12]); end
    n_cmp++; if (bus.bcd_valid_out !== 1'b0) begin n_bad++; $display("FAIL miss_bcd got %b want 0", bus.bcd_valid_out); end
    reliable_enable = 1'b0;
    p = mk_phv(1'b1, 1'b0, 32'd10);
    drive(p, 1'b1, 32'd10, 10'd2);
    step();
    bus.s_phv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_phv_info !== p) begin n_bad++; $display("FAIL disabled_passthru got %h want %h", bus.m_phv_info[127:0], p[127:0]); end
    n_cmp++; if (bus.bcd_valid_out !== 1'b0) begin n_bad++; $display("FAIL disabled_bcd got %b want 0", bus.bcd_valid_out); end
    reliable_enable = 1'b1;
    p = mk_phv(1'b0, 1'b0, 32'd10);
    drive(p, 1'b1, 32'd10, 10'd2);
    step();
    bus.s_phv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_phv_info !== p) begin n_bad++; $display("FAIL nondat_passthru got %h want %h", bus.m_phv_info[127:0], p[127:0]); end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] held;
    idle(4);
    bus.m_phv_ready = 1'b0;
    drive(mk_phv(1'b1, 1'b0, 32'd20), 1'b1, 32'd20, 10'd9);
    step();
    drive(mk_phv(1'b1, 1'b0, 32'd21), 1'b1, 32'd20, 10'd9);
    @(negedge clk);
    held = bus.m_phv_info;
    n_cmp++; if (held[455:424] !== 32'd20) begin n_bad++; $display("FAIL bp_first_psn got %h want 20", held[455:424]); end
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      n_cmp++; if (bus.s_phv_ready !== 1'b0) begin n_bad++; $display("FAIL bp_s_ready[%0d] got %b want 0", i, bus.s_phv_ready); end
      n_cmp++; if (bus.m_phv_valid !== 1'b1) begin n_bad++; $display("FAIL bp_m_valid[%0d] got %b want 1", i, bus.m_phv_valid); end
      n_cmp++; if (bus.m_phv_info !== held) begin n_bad++; $display("FAIL bp_stable[%0d] got %h want %h", i, bus.m_phv_info[455:392], held[455:392]); end
      n_cmp++; if (bus.bcd_valid_out !== 1'b0) begin n_bad++; $display("FAIL bp_bcd[%0d] got %b want 0", i, bus.bcd_valid_out); end
    end
    bus.m_phv_ready = 1'b1;
    #1;
    n_cmp++; if (bus.bcd_valid_out !== 1'b1) begin n_bad++; $display("FAIL bp_release_bcd got %b want 1", bus.bcd_valid_out); end
    n_cmp++; if (bus.bcd_flowstate_out !== 32'd21) begin n_bad++; $display("FAIL bp_release_fs got %h want 21", bus.bcd_flowstate_out); end
    n_cmp++; if (bus.s_phv_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", bus.s_phv_ready); end
    step();
    bus.s_phv_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.m_phv_valid !== 1'b1) begin n_bad++; $display("FAIL bp_replace_valid got %b want 1", bus.m_phv_valid); end
    n_cmp++; if (bus.m_phv_info[13] !== 1'b1) begin n_bad++; $display("FAIL bp_second_ack got %b want 1", bus.m_phv_info[13]); end
    n_cmp++; if (bus.m_phv_info[14] !== 1'b0) begin n_bad++; $display("FAIL bp_second_nack got %b want 0", bus.m_phv_info[14]); end
    n_cmp++; if (bus.bcd_flowstate_out !== 32'd22) begin n_bad++; $display("FAIL bp_second_fs got %h want 22", bus.bcd_flowstate_out); end
    bus.m_phv_ready = 1'b0;
    step();
    @(negedge clk);
    n_cmp++; if (bus.m_phv_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid got %b want 1", bus.m_phv_valid); end
    rst = 1'b1;
    step();
    @(negedge clk);
    n_cmp++; if (bus.m_phv_valid !== 1'b0) begin n_bad++; $display("FAIL bp_rst_valid got %b want 0", bus.m_phv_valid); end
    n_cmp++; if (bus.bcd_valid_out !== 1'b0) begin n_bad++; $display("FAIL bp_rst_bcd got %b want 0", bus.bcd_valid_out); end
    rst = 1'b0;
    bus.m_phv_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_back_to_back();
    test_gap_retry();
    test_dup_wrap();
    test_hit_rst();
    test_miss();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
